// File: rtl/hnf_pkg.sv
// Shared HN-F types and helpers: RXREQ flit layout, opcode constants and
// counter-width sizing used by the HN-F request queues.
package hnf_pkg;

  localparam logic [6:0] OPCODE_REQLCRDRETURN = 7'h00;

  typedef struct packed {
    logic [7:0] txnid;
    logic [6:0] opcode;
  } reqflit_t;

  // Bits needed to hold a credit count in the range 0..max_val inclusive.
  function automatic int unsigned crd_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hnf_sync_fifo.sv
// Generic synchronous FIFO for HN-F queues: power-of-2 depth, pointers wrap
// naturally, head entry presented combinationally from the storage array.
module hnf_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates their use.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  a_no_underflow: assert property (@(posedge clock) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/hnf_req_ingress.sv
// HN-F RXREQ ingress: L-credit issue, ingress buffering, credit-return
// filtering and credit-gated POCQ write strobe.
// Build option: HNF_REQ_INGRESS_BYPASS_EN enables a zero-latency bypass
// from rxreq_flit to req_entry while the ingress FIFO is empty.
module hnf_req_ingress
  import hnf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POCQ_DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rxreq_flitv,
  input  logic [$bits(reqflit_t)-1:0]  rxreq_flit,
  output logic                         rxreq_lcrdv,
  output logic                         req_entry_en,
  output logic [$bits(reqflit_t)-1:0]  req_entry,
  input  logic                         pocq_release,
  output logic                         err_no_credit,
  output logic                         err_credit_ovf
);

  localparam int unsigned LW = crd_w(FIFO_DEPTH);
  localparam int unsigned PW = crd_w(POCQ_DEPTH);

  reqflit_t                     flit_in;
  logic [LW-1:0]                lcrd_out;
  logic [PW-1:0]                pocq_credit;
  logic [LW-1:0]                fifo_count;
  logic [$bits(reqflit_t)-1:0]  fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         flit_ok;
  logic                         is_ret;
  logic                         pocq_avail;
  logic                         bypass;
  logic [LW+1:0]                committed;
  logic                         grant_next;

  hnf_sync_fifo #(
    .WIDTH ($bits(reqflit_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (flit_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Arrival classification, dispatch decision and POCQ write mux.
  always_comb begin
    flit_in    = rxreq_flit;
    flit_ok    = rxreq_flitv && (lcrd_out != '0);
    is_ret     = (flit_in.opcode == OPCODE_REQLCRDRETURN);
    pocq_avail = (pocq_credit != '0);
    fifo_pop   = !fifo_empty && pocq_avail;
`ifdef HNF_REQ_INGRESS_BYPASS_EN
    // A bypassed flit never occupies the FIFO, so its credit frees up as if popped at once.
    bypass       = flit_ok && !is_ret && fifo_empty && pocq_avail;
    req_entry    = fifo_pop ? fifo_head : rxreq_flit;
`else
    bypass       = 1'b0;
    req_entry    = fifo_head;
`endif
    fifo_push    = flit_ok && !is_ret && !bypass;
    req_entry_en = fifo_pop || bypass;
    committed    = (LW+2)'(fifo_count) + (LW+2)'(lcrd_out) + (LW+2)'(rxreq_lcrdv);
    grant_next   = (committed < (LW+2)'(FIFO_DEPTH));
  end

  // L-credit grant, outstanding-credit and POCQ-credit counters, sticky errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxreq_lcrdv    <= 1'b0;
      lcrd_out       <= '0;
      pocq_credit    <= PW'(POCQ_DEPTH);
      err_no_credit  <= 1'b0;
      err_credit_ovf <= 1'b0;
    end else begin
      rxreq_lcrdv <= grant_next;
      lcrd_out    <= lcrd_out + LW'(rxreq_lcrdv) - LW'(flit_ok);
      case ({req_entry_en, pocq_release})
        2'b10:   pocq_credit <= pocq_credit - 1'b1;
        2'b01:   if (pocq_credit != PW'(POCQ_DEPTH)) pocq_credit <= pocq_credit + 1'b1;
        default: pocq_credit <= pocq_credit;
      endcase
      if (pocq_release && (pocq_credit == PW'(POCQ_DEPTH))) err_credit_ovf <= 1'b1;
      if (rxreq_flitv && (lcrd_out == '0))                  err_no_credit  <= 1'b1;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_hnf_req_ingress.sv
// Directed self-checking bench for hnf_req_ingress: one instance with the
// default POCQ depth and one with POCQ_DEPTH=2 for back-pressure.
// Expectations adapt to the HNF_REQ_INGRESS_BYPASS_EN build option.
module tb_hnf_req_ingress;
  import hnf_pkg::*;

`ifdef HNF_REQ_INGRESS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int unsigned FW = $bits(reqflit_t);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst1, flitv1, lcrdv1, en1, rel1, enc1, eov1;
  reqflit_t      flit1;
  logic [FW-1:0] entry1;
  logic          rst2, flitv2, lcrdv2, en2, rel2, enc2, eov2;
  reqflit_t      flit2;
  logic [FW-1:0] entry2;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned grants1 = 0;
  int unsigned grants2 = 0;
  int unsigned disp2 = 0;
  int unsigned g, d;

  hnf_req_ingress #(.FIFO_DEPTH(4), .POCQ_DEPTH(16)) u1 (
    .clock (clock), .reset (rst1), .rxreq_flitv (flitv1), .rxreq_flit (flit1),
    .rxreq_lcrdv (lcrdv1), .req_entry_en (en1), .req_entry (entry1),
    .pocq_release (rel1), .err_no_credit (enc1), .err_credit_ovf (eov1)
  );

  hnf_req_ingress #(.FIFO_DEPTH(4), .POCQ_DEPTH(2)) u2 (
    .clock (clock), .reset (rst2), .rxreq_flitv (flitv2), .rxreq_flit (flit2),
    .rxreq_lcrdv (lcrdv2), .req_entry_en (en2), .req_entry (entry2),
    .pocq_release (rel2), .err_no_credit (enc2), .err_credit_ovf (eov2)
  );

  // Mid-cycle event counters for grants and dispatches.
  always @(negedge clock) begin
    if (lcrdv1) grants1++;
    if (lcrdv2) grants2++;
    if (en2)    disp2++;
  end

  function automatic reqflit_t mkflit(input logic [6:0] op);
    reqflit_t f;
    f.opcode = op;
    f.txnid  = {1'b0, op} ^ 8'h5A;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    rst1 = 1'b1; flitv1 = 1'b0; flit1 = '0; rel1 = 1'b0;
    rst2 = 1'b1; flitv2 = 1'b0; flit2 = '0; rel2 = 1'b0;
    tick(3);

    // Reset state
    check("rst_lcrdv", lcrdv1, 0);
    check("rst_en", en1, 0);
    check("rst_err_nc", enc1, 0);
    check("rst_err_ovf", eov1, 0);
    check("rst_pocq_credit", u1.pocq_credit, 16);
    check("rst_lcrd_out", u1.lcrd_out, 0);

    // Reset release: four consecutive grants then silence
    g = grants1;
    rst1 = 1'b0;
    rst2 = 1'b0;
    for (int unsigned k = 1; k <= 6; k++) begin
      tick(1);
      check("lcrdv_seq", lcrdv1, (k <= 4) ? 1 : 0);
    end
    check("init_grants", grants1 - g, 4);
    check("init_lcrd_out", u1.lcrd_out, 4);

    // Four back-to-back flits: order, latency, credit replenishment
    g = grants1;
    for (int unsigned k = 1; k <= 4; k++) begin
      flitv1 = 1'b1;
      flit1  = mkflit(7'(k));
      #1;
      check("entry_en", en1, (BYP || k > 1) ? 1 : 0);
      if (BYP || k > 1) check("entry_data", entry1, BYP ? mkflit(7'(k)) : mkflit(7'(k - 1)));
      tick(1);
    end
    flitv1 = 1'b0;
    #1;
    check("entry_en_last", en1, BYP ? 0 : 1);
`ifndef HNF_REQ_INGRESS_BYPASS_EN
    check("entry_data_last", entry1, mkflit(7'd4));
`endif
    tick(1);
    check("entry_en_idle", en1, 0);
    tick(8);
    check("burst_regrants", grants1 - g, 4);
    check("burst_lcrd_out", u1.lcrd_out, 4);
    check("burst_pocq_credit", u1.pocq_credit, 12);

    // Credit-return flit: consumed, not dispatched, replaced
    g = grants1;
    flitv1 = 1'b1;
    flit1  = mkflit(OPCODE_REQLCRDRETURN);
    #1;
    check("ret_no_entry", en1, 0);
    tick(1);
    flitv1 = 1'b0;
    check("ret_lcrd_dec", u1.lcrd_out, 3);
    tick(5);
    check("ret_regrant", grants1 - g, 1);
    check("ret_lcrd_out", u1.lcrd_out, 4);
    check("ret_pocq_credit", u1.pocq_credit, 12);
    check("ret_en_idle", en1, 0);

    // Flit without credit right after reset, then POCQ credit overflow
    rst1 = 1'b1;
    tick(2);
    rst1   = 1'b0;
    flitv1 = 1'b1;
    flit1  = mkflit(7'h05);
    g = grants1;
    tick(1);
    flitv1 = 1'b0;
    check("nc_err_set", enc1, 1);
    check("nc_no_entry", en1, 0);
    check("nc_fifo_count", u1.fifo_count, 0);
    check("nc_lcrd_out", u1.lcrd_out, 0);
    tick(6);
    check("nc_err_sticky", enc1, 1);
    check("nc_grants", grants1 - g, 4);
    check("ovf_err_clear", eov1, 0);
    rel1 = 1'b1;
    tick(1);
    rel1 = 1'b0;
    check("ovf_err_set", eov1, 1);
    check("ovf_saturate", u1.pocq_credit, 16);
    rst1 = 1'b1;
    tick(1);
    check("rst_clears_nc", enc1, 0);
    check("rst_clears_ovf", eov1, 0);
    rst1 = 1'b0;

    // POCQ back-pressure on the depth-2 instance
    d = disp2;
    g = grants2;
    for (int unsigned k = 1; k <= 4; k++) begin
      flitv2 = 1'b1;
      flit2  = mkflit(7'(k));
      tick(1);
    end
    flitv2 = 1'b0;
    tick(4);
    check("bp_dispatches", disp2 - d, 2);
    check("bp_regrants", grants2 - g, 2);
    check("bp_fifo_count4", u2.fifo_count, 2);
    flitv2 = 1'b1;
    flit2  = mkflit(7'h05);
    tick(1);
    flitv2 = 1'b0;
    tick(2);
    check("bp_fifo_count5", u2.fifo_count, 3);
    check("bp_stalled", en2, 0);
    check("bp_dispatches5", disp2 - d, 2);
    check("bp_lcrd_out", u2.lcrd_out, 1);
    d = disp2;
    rel2 = 1'b1;
    tick(1);
    rel2 = 1'b0;
    check("rel_en", en2, 1);
    check("rel_entry", entry2, mkflit(7'd3));
    tick(1);
    check("rel_en_stop", en2, 0);
    check("rel_fifo_count", u2.fifo_count, 2);
    check("rel_dispatches", disp2 - d, 1);

    // Mid-operation reset drops buffered flits and outstanding credits
    rst2 = 1'b1;
    tick(1);
    check("mid_rst_fifo", u2.fifo_count, 0);
    check("mid_rst_lcrd", u2.lcrd_out, 0);
    check("mid_rst_credit", u2.pocq_credit, 2);
    check("mid_rst_en", en2, 0);
    rst2 = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
